ttl_74161a_chain: RTL and testbench
===================================

# ttl_74161a_chain

Synchronous 4-bit binary counter chain modelling one or more cascaded 74LS161A devices (async clear, sync load, ENP/ENT, RCO), driven from the system clock with the emulated chip clock presented as a sampled enable. It is the stage directly upstream of the 74LS107A J-K flip-flop models in the video/timing dividers. Its terminal-count outputs feed a flip-flop's J/K or Cen input, for example as the H/V line toggles.

## Interface
Parameters:
- BLOCKS, 2, number of cascaded 4-bit stages (1..8); counter width is 4*BLOCKS.

Ports:
- Clk  input  1  system clock; all state changes except clear occur on its rising edge.
- CLRn  input  1  reset: asynchronous, active-low (the chip's CLR pin); forces counter and all state to reset values.
- Cen  input  1  emulated chip CLK pin, sampled on Clk.
- LOADn  input  1  synchronous parallel load, active-low.
- ENP  input  1  count enable P, common to all stages.
- ENT  input  1  count enable T into stage 0.
- D  input  4*BLOCKS  parallel load data; stage i uses D[4i+3:4i].
- Q  output  4*BLOCKS  counter value; stage i on Q[4i+3:4i].
- RCO  output  BLOCKS  ripple-carry of each stage; RCO[BLOCKS-1] is the chain carry.
- Tick  output  1  one-Clk pulse on counting wrap of the full chain.

## Operation
- Chip clock event: a Cen low-to-high transition, detected at a Clk rising edge when Cen is 1 and the registered previous sample is 0. This matches the rising-edge-triggered 74LS161A. The history register is updated on every Clk edge while CLRn is high.
- ENT chain: ENT_0 = ENT; ENT_(i+1) = RCO[i].
- RCO[i] = ENT_i AND (stage i == 4'hF). It is combinational from Q and ENT and independent of ENP and Cen, as on the real part.
- On an event, in priority order:
  - LOADn = 0: every stage loads its D slice, regardless of ENP/ENT.
  - Otherwise, each stage i with ENP = 1 and ENT_i = 1 increments modulo 16.
  - Otherwise the stage holds.
- All stage decisions in one event use the pre-event Q values. The chain therefore behaves as a single 4*BLOCKS-bit binary counter that wraps from all-ones to 0.
- Tick: set to 1 at the event edge where a count (not a load) takes Q from all-ones to 0 with ENP = ENT = 1. It is cleared at the next Clk edge.
- No event: Q, RCO and Tick hold; Tick returns to 0.

## Timing
- Reset values while CLRn = 0, effective immediately and independent of Clk:
  - Q = 0.
  - RCO = 0 (unless ENT = 1 with BLOCKS = 0 is impossible; RCO follows Q = 0, so it is 0).
  - Tick = 0.
  - Cen history = 1.
- History reset to 1 means a Cen that is already high at CLRn release causes no event. The first event needs Cen to go low, then high.
- CLRn low overrides LOADn, ENP/ENT and any event on the same edge.
- CLRn released between Clk edges: the first state update is at the next Clk rising edge.
- Latency: Q reflects load or count at the Clk edge that first samples Cen = 1, i.e. visible one Clk after Cen rises. RCO follows Q combinationally in the same cycle.
- Cen must stay low and high for at least one Clk period each. A pulse shorter than one Clk may be missed, and that is accepted.
- Cen held high: exactly one event. Cen static: no events.
- LOADn, ENP, ENT and D are sampled only at event edges; changes between events have no effect on Q.
- Tick width is exactly one Clk cycle. It is coincident with Q = 0 after wrap, and RCO[BLOCKS-1] = 0 in that cycle.

## Test plan
- Reset: BLOCKS=2, drive CLRn=0 mid-count at Q=8'h5A -> Q=0, RCO=0, Tick=0 asynchronously. Release with Cen=1 held -> no increment until Cen goes 0 then 1.
- Count/cascade: ENP=ENT=LOADn=1, 20 Cen rising edges from 0 -> Q=8'h14. RCO[0]=1 only while Q[3:0]=4'hF with ENT=1.
- Load priority: Q=8'h33, LOADn=0, ENP=0, D=8'hA7, one Cen edge -> Q=8'hA7. A Cen edge coincident with CLRn=0 -> Q=0.
- Enables: Q=8'h0F, ENT=1, ENP=0, 3 Cen edges -> Q stays 8'h0F, RCO[0]=1. Set ENT=0 -> RCO[0]=0 with no Clk edge needed.
- Wrap: load 8'hFE, then 2 counting Cen edges -> Q=8'hFF with RCO=2'b11, then Q=8'h00 with Tick=1 for exactly one Clk. Loading 8'h00 from 8'hFF -> Tick stays 0.
- Cen sampling: Cen held high 50 Clks -> exactly one increment. Cen toggling every Clk -> one increment per two Clks.

Source files
------------

// File: rtl/ttl_74161a_chain.sv
// Cascaded 74LS161A 4-bit counters clocked by Clk, with the chip CLK pin sampled on Cen.
// Stages share LOADn/ENP; ENT ripples through each stage's RCO, so the chain counts as one wide binary counter.
module ttl_74161a_chain #(
  parameter int BLOCKS = 2
) (
  input  logic                  Clk,
  input  logic                  CLRn,
  input  logic                  Cen,
  input  logic                  LOADn,
  input  logic                  ENP,
  input  logic                  ENT,
  input  logic [4*BLOCKS-1:0]   D,
  output logic [4*BLOCKS-1:0]   Q,
  output logic [BLOCKS-1:0]     RCO,
  output logic                  Tick
);

  logic                cen_prev_p0;
  logic [4*BLOCKS-1:0] q_p0;
  logic                tick_p0;

  logic                chip_edge;
  logic [BLOCKS-1:0]   stage_full;
  logic [BLOCKS-1:0]   rco_c;
  logic [BLOCKS-1:0]   ent_c;
  logic [4*BLOCKS-1:0] q_next;
  logic                wrap;

  function automatic logic [3:0] inc4(input logic [3:0] v);
    return v + 4'd1;
  endfunction

  assign chip_edge = Cen & ~cen_prev_p0;

  // RCO depends only on Q and ENT, never on ENP or Cen.
  always_comb begin
    logic acc;
    acc        = ENT;
    stage_full = '0;
    rco_c      = '0;
    ent_c      = '0;
    for (int i = 0; i < BLOCKS; i++) begin
      stage_full[i] = (q_p0[4*i +: 4] == 4'hF);
      ent_c[i]      = acc;
      acc           = acc & stage_full[i];
      rco_c[i]      = acc;
    end
  end

  always_comb begin
    q_next = q_p0;
    if (!LOADn) begin
      q_next = D;
    end else begin
      for (int i = 0; i < BLOCKS; i++) begin
        if (ENP && ent_c[i]) q_next[4*i +: 4] = inc4(q_p0[4*i +: 4]);
      end
    end
  end

  assign wrap = LOADn & ENP & rco_c[BLOCKS-1];

  // Stage p0: Cen history, counter state and wrap pulse
  always_ff @(posedge Clk or negedge CLRn) begin
    if (!CLRn) begin
      cen_prev_p0 <= 1'b1;
      q_p0        <= '0;
      tick_p0     <= 1'b0;
    end else begin
      cen_prev_p0 <= Cen;
      tick_p0     <= chip_edge & wrap;
      if (chip_edge) q_p0 <= q_next;
    end
  end

  assign Q    = q_p0;
  assign RCO  = rco_c;
  assign Tick = tick_p0;

endmodule

// File: tb/tb_ttl_74161a_chain.sv
// Directed bench for ttl_74161a_chain (BLOCKS=2): reset, cascade counting, load priority, enables, wrap and Cen sampling.
module tb_ttl_74161a_chain;

  logic       Clk = 1'b0;
  logic       CLRn, Cen, LOADn, ENP, ENT;
  logic [7:0] D;
  logic [7:0] Q;
  logic [1:0] RCO;
  logic       Tick;

  int tests = 0;
  int failed = 0;

  ttl_74161a_chain #(.BLOCKS(2)) dut (
    .Clk(Clk), .CLRn(CLRn), .Cen(Cen), .LOADn(LOADn), .ENP(ENP), .ENT(ENT),
    .D(D), .Q(Q), .RCO(RCO), .Tick(Tick)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One chip clock: Cen low for a Clk, then high; returns at the negedge after the event edge.
  task automatic pulse();
    @(negedge Clk) Cen = 1'b0;
    @(negedge Clk) Cen = 1'b1;
    @(negedge Clk);
  endtask

  task automatic load(input logic [7:0] v);
    LOADn = 1'b0; D = v;
    pulse();
    LOADn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    CLRn = 1'b0; Cen = 1'b0; LOADn = 1'b1; ENP = 1'b1; ENT = 1'b1; D = 8'h00;
    #2;
    chk("reset_q", {8'h0, Q}, 16'h0000);
    chk("reset_rco", {14'h0, RCO}, 16'h0000);
    chk("reset_tick", {15'h0, Tick}, 16'h0000);
    @(negedge Clk) CLRn = 1'b1;

    // Count 20 chip clocks, observing the stage-0 carry on the way
    for (int i = 0; i < 15; i++) pulse();
    chk("cnt_0f_q", {8'h0, Q}, 16'h000F);
    chk("cnt_0f_rco", {14'h0, RCO}, 16'h0001);
    for (int i = 0; i < 5; i++) pulse();
    chk("cnt_20_q", {8'h0, Q}, 16'h0014);
    chk("cnt_20_rco", {14'h0, RCO}, 16'h0000);

    // Inputs change without a Cen edge: no effect
    LOADn = 1'b0; D = 8'hFF;
    repeat (4) @(negedge Clk);
    chk("static_cen_q", {8'h0, Q}, 16'h0014);
    LOADn = 1'b1;

    // Asynchronous clear mid-count
    load(8'h5A);
    chk("load_5a", {8'h0, Q}, 16'h005A);
    #2 CLRn = 1'b0;
    #1;
    chk("async_clr_q", {8'h0, Q}, 16'h0000);
    chk("async_clr_rco", {14'h0, RCO}, 16'h0000);
    chk("async_clr_tick", {15'h0, Tick}, 16'h0000);
    Cen = 1'b1;
    @(negedge Clk) CLRn = 1'b1;
    repeat (3) @(negedge Clk);
    chk("release_cen_high", {8'h0, Q}, 16'h0000);
    pulse();
    chk("first_event", {8'h0, Q}, 16'h0001);

    // Load priority over disabled counting
    load(8'h33);
    chk("load_33", {8'h0, Q}, 16'h0033);
    ENP = 1'b0;
    load(8'hA7);
    chk("load_enp0", {8'h0, Q}, 16'h00A7);
    ENP = 1'b1;

    // Cen edge coincident with clear
    @(negedge Clk) Cen = 1'b0;
    @(negedge Clk) begin Cen = 1'b1; CLRn = 1'b0; end
    @(negedge Clk);
    chk("clr_overrides_event", {8'h0, Q}, 16'h0000);
    CLRn = 1'b1;
    repeat (2) @(negedge Clk);
    chk("clr_release_no_event", {8'h0, Q}, 16'h0000);

    // Enables
    load(8'h0F);
    ENP = 1'b0;
    for (int i = 0; i < 3; i++) pulse();
    chk("enp0_hold_q", {8'h0, Q}, 16'h000F);
    chk("enp0_rco", {14'h0, RCO}, 16'h0001);
    ENT = 1'b0;
    #1;
    chk("ent0_rco_comb", {14'h0, RCO}, 16'h0000);
    pulse();
    chk("ent0_hold_q", {8'h0, Q}, 16'h000F);
    ENT = 1'b1; ENP = 1'b1;

    // Full-chain wrap and Tick
    load(8'hFE);
    pulse();
    chk("wrap_ff_q", {8'h0, Q}, 16'h00FF);
    chk("wrap_ff_rco", {14'h0, RCO}, 16'h0003);
    chk("wrap_ff_tick", {15'h0, Tick}, 16'h0000);
    pulse();
    chk("wrap_00_q", {8'h0, Q}, 16'h0000);
    chk("wrap_tick_hi", {15'h0, Tick}, 16'h0001);
    chk("wrap_rco", {14'h0, RCO}, 16'h0000);
    @(negedge Clk);
    chk("wrap_tick_lo", {15'h0, Tick}, 16'h0000);
    load(8'hFF);
    load(8'h00);
    chk("load_wrap_q", {8'h0, Q}, 16'h0000);
    chk("load_wrap_tick", {15'h0, Tick}, 16'h0000);

    // Cen held high: one event only
    @(negedge Clk) Cen = 1'b0;
    @(negedge Clk) Cen = 1'b1;
    repeat (50) @(negedge Clk);
    chk("cen_held_high", {8'h0, Q}, 16'h0001);

    // Cen toggling each Clk: one count per two Clks
    for (int i = 0; i < 20; i++) @(negedge Clk) Cen = ~Cen;
    @(negedge Clk);
    chk("cen_toggle", {8'h0, Q}, 16'h000B);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
